// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority,
// long-latency results queue in a FIFO and drain into idle write slots.
module wb_write_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic        sb_set,
    input  logic [4:0]  sb_set_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd_chk,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rd_busy,
    output logic        stall_req,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL  = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] LIMIT = AW'(STARVE_LIMIT);

    logic [4:0]    fifo_rd   [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic [AW-1:0] age;
    logic [31:0]   sb;

    logic        pipe_win;
    logic        has_head;
    logic        full;
    logic        push;
    logic        pop;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    assign pipe_win  = pipe_we && (pipe_rd != 5'd0);
    assign has_head  = (cnt != '0);
    assign full      = (cnt == FULL);
    assign pop       = !pipe_win && has_head;
    assign push      = lu_valid && !full;
    assign head_rd   = fifo_rd[rptr];
    assign head_data = fifo_data[rptr];

    // Write-port mux: pipeline first, otherwise drain the FIFO head
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (!rst_n) begin
            rf_we = 1'b0;
        end else if (pipe_win) begin
            rf_we    = 1'b1;
            rf_waddr = pipe_rd;
            rf_wdata = pipe_data;
        end else if (has_head) begin
            rf_we    = (head_rd != 5'd0);
            rf_waddr = head_rd;
            rf_wdata = head_data;
        end
    end

    assign lu_ready  = rst_n && !full;
    assign stall_req = rst_n && ((age >= LIMIT) || full);
    assign rs1_busy  = rst_n && sb[rs1];
    assign rs2_busy  = rst_n && sb[rs2];
    assign rd_busy   = rst_n && sb[rd_chk];

    // Result storage; contents are only meaningful below cnt
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wptr]   <= lu_rd;
            fifo_data[wptr] <= lu_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Head age: counts cycles the head is held off the port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if (pop || !has_head) begin
            age <= '0;
        end else if (age < LIMIT) begin
            age <= age + AW'(1);
        end
    end

    // Scoreboard: a new dispatch overrides a same-cycle retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            if (pop && (head_rd != 5'd0)) sb[head_rd] <= 1'b0;
            if (sb_set && (sb_set_rd != 5'd0)) sb[sb_set_rd] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed vector table,
// hand-written reset sequences and randomized traffic against a queue model.
module tb_wb_write_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        sb_set;
    logic [4:0]  sb_set_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd_chk;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_busy;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks = 0;
    int failures = 0;

    wb_write_arbiter #(
        .FIFO_DEPTH  (DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pipe_we  (pipe_we),
        .pipe_rd  (pipe_rd),
        .pipe_data(pipe_data),
        .lu_valid (lu_valid),
        .lu_rd    (lu_rd),
        .lu_data  (lu_data),
        .lu_ready (lu_ready),
        .sb_set   (sb_set),
        .sb_set_rd(sb_set_rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd_chk   (rd_chk),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy),
        .stall_req(stall_req),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    bit   sb_m[32];
    int   age_m;

    typedef struct {
        logic        pwe;
        logic [4:0]  prd;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        ss;
        logic [4:0]  srd;
        logic [4:0]  r1;
        logic        ewe;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        erdy;
        logic        est;
        logic        eb;
    } vec_t;

    vec_t vt[28];

    function automatic vec_t mk(
        input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
        input logic ss, input logic [4:0] srd, input logic [4:0] r1,
        input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
        input logic erdy, input logic est, input logic eb);
        vec_t v;
        v.pwe = pwe; v.prd = prd; v.pd = pd;
        v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.ss = ss; v.srd = srd; v.r1 = r1;
        v.ewe = ewe; v.ea = ea; v.ed = ed;
        v.erdy = erdy; v.est = est; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (sb_m[i]) sb_m[i] = 1'b0;
        age_m = 0;
    endtask

    function automatic bit mbusy(input logic [4:0] r);
        return (r != 5'd0) && sb_m[r];
    endfunction

    // Expected outputs for the current inputs, from the spec's rules
    task automatic model_check(input string tag);
        bit win;
        win = pipe_we && (pipe_rd != 5'd0);
        if (win) begin
            chk({tag, "_we"}, 32'(rf_we), 32'd1);
            chk({tag, "_addr"}, 32'(rf_waddr), 32'(pipe_rd));
            chk({tag, "_data"}, rf_wdata, pipe_data);
        end else if (q.size() > 0) begin
            chk({tag, "_we"}, 32'(rf_we), 32'(q[0].rd != 5'd0));
            if (q[0].rd != 5'd0) begin
                chk({tag, "_addr"}, 32'(rf_waddr), 32'(q[0].rd));
                chk({tag, "_data"}, rf_wdata, q[0].d);
            end
        end else begin
            chk({tag, "_we"}, 32'(rf_we), 32'd0);
        end
        chk({tag, "_ready"}, 32'(lu_ready), 32'(q.size() < DEPTH));
        chk({tag, "_stall"}, 32'(stall_req),
            32'((age_m >= LIMIT) || (q.size() == DEPTH)));
        chk({tag, "_b1"}, 32'(rs1_busy), 32'(mbusy(rs1)));
        chk({tag, "_b2"}, 32'(rs2_busy), 32'(mbusy(rs2)));
        chk({tag, "_bd"}, 32'(rd_busy), 32'(mbusy(rd_chk)));
    endtask

    // Advance the model across one rising edge
    task automatic model_update();
        bit   win;
        bit   pop;
        bit   push;
        int   sz;
        ent_t e;
        win  = pipe_we && (pipe_rd != 5'd0);
        sz   = q.size();
        pop  = !win && (sz > 0);
        push = lu_valid && (sz < DEPTH);
        if (pop || sz == 0) age_m = 0;
        else if (age_m < LIMIT) age_m = age_m + 1;
        if (pop) begin
            e = q.pop_front();
            if (e.rd != 5'd0) sb_m[e.rd] = 1'b0;
        end
        if (sb_set && sb_set_rd != 5'd0) sb_m[sb_set_rd] = 1'b1;
        if (push) begin
            e.rd = lu_rd;
            e.d  = lu_data;
            q.push_back(e);
        end
    endtask

    task automatic idle_inputs();
        pipe_we = 0; pipe_rd = 0; pipe_data = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0;
        sb_set = 0; sb_set_rd = 0;
        rs1 = 0; rs2 = 0; rd_chk = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        vt[0]  = mk(0,0,0,          0,0,0,           1,5,5,  0,0,0,           1,0,0);
        vt[1]  = mk(0,0,0,          1,5,32'hDEADBEEF,0,0,5,  0,0,0,           1,0,1);
        vt[2]  = mk(0,0,0,          0,0,0,           0,0,5,  1,5,32'hDEADBEEF,1,0,1);
        vt[3]  = mk(0,0,0,          0,0,0,           0,0,5,  0,0,0,           1,0,0);
        vt[4]  = mk(1,3,32'h11,     1,9,32'hA1,      0,0,0,  1,3,32'h11,      1,0,0);
        vt[5]  = mk(1,3,32'h11,     1,10,32'hA2,     0,0,0,  1,3,32'h11,      1,0,0);
        vt[6]  = mk(1,3,32'h11,     1,11,32'hA3,     0,0,0,  1,3,32'h11,      0,1,0);
        vt[7]  = mk(0,0,0,          0,0,0,           0,0,0,  1,9,32'hA1,      0,1,0);
        vt[8]  = mk(0,0,0,          0,0,0,           0,0,0,  1,10,32'hA2,     1,0,0);
        vt[9]  = mk(0,0,0,          0,0,0,           0,0,0,  0,0,0,           1,0,0);
        vt[10] = mk(1,3,32'h22,     1,12,32'hC0,     0,0,0,  1,3,32'h22,      1,0,0);
        vt[11] = mk(1,3,32'h22,     0,0,0,           0,0,0,  1,3,32'h22,      1,0,0);
        vt[12] = mk(1,3,32'h22,     0,0,0,           0,0,0,  1,3,32'h22,      1,0,0);
        vt[13] = mk(1,3,32'h22,     0,0,0,           0,0,0,  1,3,32'h22,      1,0,0);
        vt[14] = mk(1,3,32'h22,     0,0,0,           0,0,0,  1,3,32'h22,      1,0,0);
        vt[15] = mk(1,3,32'h22,     0,0,0,           0,0,0,  1,3,32'h22,      1,1,0);
        vt[16] = mk(0,0,0,          0,0,0,           0,0,0,  1,12,32'hC0,     1,1,0);
        vt[17] = mk(0,0,0,          0,0,0,           0,0,0,  0,0,0,           1,0,0);
        vt[18] = mk(0,0,0,          1,13,32'hD0,     0,0,0,  0,0,0,           1,0,0);
        vt[19] = mk(1,0,32'h99,     0,0,0,           0,0,0,  1,13,32'hD0,     1,0,0);
        vt[20] = mk(0,0,0,          1,0,32'hE0,      0,0,0,  0,0,0,           1,0,0);
        vt[21] = mk(0,0,0,          0,0,0,           0,0,0,  0,0,0,           1,0,0);
        vt[22] = mk(1,3,32'h33,     1,14,32'hE1,     0,0,0,  1,3,32'h33,      1,0,0);
        vt[23] = mk(0,0,0,          0,0,0,           0,0,0,  1,14,32'hE1,     1,0,0);
        vt[24] = mk(0,0,0,          0,0,0,           1,7,0,  0,0,0,           1,0,0);
        vt[25] = mk(0,0,0,          1,7,32'h77,      0,0,7,  0,0,0,           1,0,1);
        vt[26] = mk(0,0,0,          0,0,0,           1,7,7,  1,7,32'h77,      1,0,1);
        vt[27] = mk(0,0,0,          0,0,0,           0,0,7,  0,0,0,           1,0,1);

        // Reset state
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        rs1 = 5'd5;
        #3;
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_ready", 32'(lu_ready), 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_busy", 32'(rs1_busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(lu_ready), 32'd1);
        chk("post_rst_we", 32'(rf_we), 32'd0);
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 28; i++) begin
            idle_inputs();
            pipe_we = vt[i].pwe; pipe_rd = vt[i].prd; pipe_data = vt[i].pd;
            lu_valid = vt[i].lv; lu_rd = vt[i].lrd; lu_data = vt[i].ld;
            sb_set = vt[i].ss; sb_set_rd = vt[i].srd; rs1 = vt[i].r1;
            #1;
            chk($sformatf("vec%0d_we", i), 32'(rf_we), 32'(vt[i].ewe));
            if (vt[i].ewe) begin
                chk($sformatf("vec%0d_addr", i), 32'(rf_waddr), 32'(vt[i].ea));
                chk($sformatf("vec%0d_data", i), rf_wdata, vt[i].ed);
            end
            chk($sformatf("vec%0d_ready", i), 32'(lu_ready), 32'(vt[i].erdy));
            chk($sformatf("vec%0d_stall", i), 32'(stall_req), 32'(vt[i].est));
            chk($sformatf("vec%0d_busy", i), 32'(rs1_busy), 32'(vt[i].eb));
            model_check($sformatf("vec%0d_m", i));
            tick();
        end

        // Async reset in the middle of a drain with two buffered results
        idle_inputs();
        pipe_we = 1; pipe_rd = 3; pipe_data = 32'h44;
        lu_valid = 1; lu_rd = 20; lu_data = 32'h120;
        sb_set = 1; sb_set_rd = 20;
        #1 model_check("ar_p0");
        tick();
        lu_rd = 21; lu_data = 32'h121; sb_set_rd = 21;
        #1 model_check("ar_p1");
        tick();
        idle_inputs();
        rs1 = 7; rs2 = 20; rd_chk = 21;
        #1;
        chk("ar_pre_we", 32'(rf_we), 32'd1);
        chk("ar_pre_addr", 32'(rf_waddr), 32'd20);
        chk("ar_pre_stall", 32'(stall_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_we", 32'(rf_we), 32'd0);
        chk("ar_ready", 32'(lu_ready), 32'd0);
        chk("ar_stall", 32'(stall_req), 32'd0);
        chk("ar_b1", 32'(rs1_busy), 32'd0);
        chk("ar_b2", 32'(rs2_busy), 32'd0);
        chk("ar_bd", 32'(rd_busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ar_rel_we", 32'(rf_we), 32'd0);
        chk("ar_rel_ready", 32'(lu_ready), 32'd1);
        chk("ar_rel_b1", 32'(rs1_busy), 32'd0);
        chk("ar_rel_b2", 32'(rs2_busy), 32'd0);
        chk("ar_rel_bd", 32'(rd_busy), 32'd0);
        model_check("ar_rel_m");
        tick();

        // Randomized traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            pipe_we   = 1'($urandom_range(0, 1));
            pipe_rd   = 5'($urandom_range(0, 7));
            pipe_data = $urandom;
            lu_valid  = 1'($urandom_range(0, 1));
            lu_rd     = 5'($urandom_range(0, 7));
            lu_data   = $urandom;
            sb_set    = ($urandom_range(0, 3) == 0);
            sb_set_rd = 5'($urandom_range(0, 7));
            rs1       = 5'($urandom_range(0, 7));
            rs2       = 5'($urandom_range(0, 7));
            rd_chk    = 5'($urandom_range(0, 7));
            #1 model_check($sformatf("rnd%0d", n));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
